// File: rtl/sw_debounce.sv
// Purpose : per-bit switch synchroniser + stability filter, clean levels and edge pulses.
// Latency : SWI change captured at edge E0 reaches sw_db at E(1+STABLE_CYCLES); 5 edges by default.
// Backpr. : none; free-running, every channel sampled every clk_2 cycle.
//
// Ports:
//   clk_2    - single clock, all state on rising edge
//   reset_n  - asynchronous active-low reset (clears sync flops, counters, outputs)
//   SWI      - raw asynchronous bouncing switch inputs, NBITS wide
//   sw_db    - debounced levels
//   sw_rise  - one-cycle pulse on accepted 0->1, aligned with first cycle of new sw_db
//   sw_fall  - one-cycle pulse on accepted 1->0, aligned with first cycle of new sw_db
//
// Build option: define SW_DEBOUNCE_EDGE_EN to build the edge-pulse flops; when it is
// undefined sw_rise/sw_fall are tied to 0 and sw_db behaviour is unchanged.
module sw_debounce #(
  parameter int NBITS         = 8,
  parameter int STABLE_CYCLES = 4   // legal 2..65535
) (
  input  logic             clk_2,
  input  logic             reset_n,
  input  logic [NBITS-1:0] SWI,
  output logic [NBITS-1:0] sw_db,
  output logic [NBITS-1:0] sw_rise,
  output logic [NBITS-1:0] sw_fall
);

  localparam int             CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [NBITS-1:0] s1;
  logic [NBITS-1:0] s2;
  // High for a bit on the edge where its new value is taken into sw_db.
  logic [NBITS-1:0] accept;

  // Two-flop synchroniser; only s2 is seen by the filter.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= SWI;
      s2 <= s1;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NBITS; g++) begin : g_chan
      logic [CW-1:0] cnt;

      // The counter holds the number of consecutive differing samples already seen;
      // the STABLE_CYCLES-th differing sample is the one that commits the new level,
      // so the count never needs to reach STABLE_CYCLES itself.
      assign accept[g] = (s2[g] != sw_db[g]) && (cnt == CNT_LAST);

      always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
          cnt      <= '0;
          sw_db[g] <= 1'b0;
        end else if (s2[g] == sw_db[g]) begin
          // Any return to the accepted level discards the partial count.
          cnt <= '0;
        end else if (accept[g]) begin
          cnt      <= '0;
          sw_db[g] <= s2[g];
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  endgenerate

`ifdef SW_DEBOUNCE_EDGE_EN
  // Registered on the same edge as sw_db, so each pulse lines up with the
  // first cycle of the new level and drops on the following edge.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      sw_rise <= '0;
      sw_fall <= '0;
    end else begin
      sw_rise <= accept & s2;
      sw_fall <= accept & ~s2;
    end
  end
`else
  assign sw_rise = '0;
  assign sw_fall = '0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
module tb_sw_debounce;

  logic       clk_2;
  logic       reset_n;
  logic [7:0] SWI;
  logic [7:0] sw_db;
  logic [7:0] sw_rise;
  logic [7:0] sw_fall;

  int checks;
  int errors;

`ifdef SW_DEBOUNCE_EDGE_EN
  localparam logic [7:0] PM = 8'hFF;  // pulse outputs expected live
`else
  localparam logic [7:0] PM = 8'h00;  // pulse outputs expected tied low
`endif

  sw_debounce #(.NBITS(8), .STABLE_CYCLES(4)) dut (
    .clk_2  (clk_2),
    .reset_n(reset_n),
    .SWI    (SWI),
    .sw_db  (sw_db),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  // Advance one rising edge, then settle 1 time unit for sampling/driving.
  task automatic step();
    @(posedge clk_2);
    #1;
  endtask

  // Reset with switches high, then release; expect a normal rising acceptance.
  task automatic test_reset();
    logic [7:0] edb, er;
    reset_n = 1'b0;
    SWI     = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({sw_db, sw_rise, sw_fall} !== 24'h0) begin
        errors++;
        $display("FAIL reset_hold k=%0d got db=%h rise=%h fall=%h exp all 00", k, sw_db, sw_rise, sw_fall);
      end
    end
    reset_n = 1'b1;
    // k counts edges after release; the first one (k=0) is E0.
    for (int k = 0; k <= 6; k++) begin
      step();
      edb = (k >= 5) ? 8'hFF : 8'h00;
      er  = (k == 5) ? (8'hFF & PM) : 8'h00;
      checks++;
      if (sw_db !== edb) begin
        errors++;
        $display("FAIL reset_rise_db E%0d got %h exp %h", k, sw_db, edb);
      end
      checks++;
      if (sw_rise !== er) begin
        errors++;
        $display("FAIL reset_rise_pulse E%0d got %h exp %h", k, sw_rise, er);
      end
      checks++;
      if (sw_fall !== 8'h00) begin
        errors++;
        $display("FAIL reset_rise_fall E%0d got %h exp 00", k, sw_fall);
      end
    end
  endtask

  // All switches drop together: one fall pulse per bit, 5 edges after E0.
  task automatic test_fall_all();
    logic [7:0] edb, ef;
    SWI = 8'h00;
    for (int k = 0; k <= 6; k++) begin
      step();
      edb = (k >= 5) ? 8'h00 : 8'hFF;
      ef  = (k == 5) ? (8'hFF & PM) : 8'h00;
      checks++;
      if (sw_db !== edb) begin
        errors++;
        $display("FAIL fall_db E%0d got %h exp %h", k, sw_db, edb);
      end
      checks++;
      if (sw_fall !== ef || sw_rise !== 8'h00) begin
        errors++;
        $display("FAIL fall_pulse E%0d got fall=%h rise=%h exp fall=%h rise=00", k, sw_fall, sw_rise, ef);
      end
    end
  endtask

  // Single bit clean toggle; other bits must stay put.
  task automatic test_clean_toggle();
    logic [7:0] edb, er;
    SWI = 8'h02;
    for (int k = 0; k <= 6; k++) begin
      step();
      edb = (k >= 5) ? 8'h02 : 8'h00;
      er  = (k == 5) ? (8'h02 & PM) : 8'h00;
      checks++;
      if (sw_db !== edb) begin
        errors++;
        $display("FAIL toggle_db E%0d got %h exp %h", k, sw_db, edb);
      end
      checks++;
      if (sw_rise !== er || sw_fall !== 8'h00) begin
        errors++;
        $display("FAIL toggle_pulse E%0d got rise=%h fall=%h exp rise=%h fall=00", k, sw_rise, sw_fall, er);
      end
    end
    // Return to idle and let it settle (fall pulse not checked here).
    SWI = 8'h00;
    for (int k = 0; k < 8; k++) step();
    checks++;
    if (sw_db !== 8'h00) begin
      errors++;
      $display("FAIL toggle_return got %h exp 00", sw_db);
    end
  endtask

  // Bit 0 bounces 1,0,1,0 then stays 1; only the final rise is accepted.
  task automatic test_bounce();
    logic [7:0] edb, er;
    logic [3:0] pat;
    pat = 4'b0101;  // applied LSB first: 1,0,1,0
    for (int c = 0; c < 4; c++) begin
      SWI = {7'b0, pat[c]};
      step();
      checks++;
      if ({sw_db, sw_rise, sw_fall} !== 24'h0) begin
        errors++;
        $display("FAIL bounce_toggling c=%0d got db=%h rise=%h fall=%h exp all 00", c, sw_db, sw_rise, sw_fall);
      end
    end
    SWI = 8'h01;
    // k=0 is the edge that captures the last 0->1 toggle.
    for (int k = 0; k <= 6; k++) begin
      step();
      edb = (k >= 5) ? 8'h01 : 8'h00;
      er  = (k == 5) ? (8'h01 & PM) : 8'h00;
      checks++;
      if (sw_db !== edb) begin
        errors++;
        $display("FAIL bounce_db E%0d got %h exp %h", k, sw_db, edb);
      end
      checks++;
      if (sw_rise !== er || sw_fall !== 8'h00) begin
        errors++;
        $display("FAIL bounce_pulse E%0d got rise=%h fall=%h exp rise=%h fall=00", k, sw_rise, sw_fall, er);
      end
    end
  endtask

  // Bit 3 high for STABLE_CYCLES-1 cycles: must be rejected entirely.
  task automatic test_glitch();
    SWI = 8'h09;
    for (int k = 0; k < 3; k++) step();
    SWI = 8'h01;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (sw_db !== 8'h01 || sw_rise !== 8'h00 || sw_fall !== 8'h00) begin
        errors++;
        $display("FAIL glitch k=%0d got db=%h rise=%h fall=%h exp db=01 rise=00 fall=00", k, sw_db, sw_rise, sw_fall);
      end
    end
  endtask

  // Reset asserted mid-count on bit 2; the count restarts after release.
  task automatic test_reset_mid_count();
    logic [7:0] edb, er;
    SWI = 8'h00;
    for (int k = 0; k < 8; k++) step();  // bit 0 falls, settle
    SWI = 8'h04;
    step();  // E0
    step();  // E1
    step();  // E2
    reset_n = 1'b0;
    #1;
    checks++;
    if ({sw_db, sw_rise, sw_fall} !== 24'h0) begin
      errors++;
      $display("FAIL midreset_assert got db=%h rise=%h fall=%h exp all 00", sw_db, sw_rise, sw_fall);
    end
    step();  // E3
    step();  // E4
    step();  // E5
    step();  // E6
    reset_n = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      step();
      edb = (k >= 5) ? 8'h04 : 8'h00;
      er  = (k == 5) ? (8'h04 & PM) : 8'h00;
      checks++;
      if (sw_db !== edb) begin
        errors++;
        $display("FAIL midreset_db E%0d got %h exp %h", k, sw_db, edb);
      end
      checks++;
      if (sw_rise !== er || sw_fall !== 8'h00) begin
        errors++;
        $display("FAIL midreset_pulse E%0d got rise=%h fall=%h exp rise=%h fall=00", k, sw_rise, sw_fall, er);
      end
    end
  endtask

  // 0F -> F0: independent channels rise and fall on the same edge.
  task automatic test_independence();
    logic [7:0] edb, er, ef;
    SWI = 8'h0F;
    for (int k = 0; k < 8; k++) step();
    checks++;
    if (sw_db !== 8'h0F) begin
      errors++;
      $display("FAIL indep_setup got %h exp 0f", sw_db);
    end
    SWI = 8'hF0;
    for (int k = 0; k <= 6; k++) begin
      step();
      edb = (k >= 5) ? 8'hF0 : 8'h0F;
      er  = (k == 5) ? (8'hF0 & PM) : 8'h00;
      ef  = (k == 5) ? (8'h0F & PM) : 8'h00;
      checks++;
      if (sw_db !== edb) begin
        errors++;
        $display("FAIL indep_db E%0d got %h exp %h", k, sw_db, edb);
      end
      checks++;
      if (sw_rise !== er) begin
        errors++;
        $display("FAIL indep_rise E%0d got %h exp %h", k, sw_rise, er);
      end
      checks++;
      if (sw_fall !== ef) begin
        errors++;
        $display("FAIL indep_fall E%0d got %h exp %h", k, sw_fall, ef);
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    SWI     = 8'h00;
    test_reset();
    test_fall_all();
    test_clean_toggle();
    test_bounce();
    test_glitch();
    test_reset_mid_count();
    test_independence();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Per-bit switch conditioner between the board switches and the up/down hex counter stage. Synchronises each raw `SWI` bit into the `clk_2` domain, filters contact bounce with a per-bit stability counter, and presents clean levels plus single-cycle rise/fall pulses. The counter stage uses the clean levels `sw_db[0]` and `sw_db[1]` for its reset and direction controls, in place of the raw switches.

## Interface
Parameters:
- `NBITS` — default 8 — number of independent switch channels.
- `STABLE_CYCLES` — default 4 — consecutive synchronised samples a new value must hold before it is accepted. Legal range 2..65535.

Ports:
- `clk_2` — in — 1 — single clock; all state updates on its rising edge.
- `reset_n` — in — 1 — asynchronous, active-low reset.
- `SWI` — in — NBITS — raw, asynchronous, bouncing switch inputs.
- `sw_db` — out — NBITS — debounced levels.
- `sw_rise` — out — NBITS — one-cycle pulse per bit on an accepted 0→1 transition.
- `sw_fall` — out — NBITS — one-cycle pulse per bit on an accepted 1→0 transition.

## Operation
- **Synchroniser:** two flops per bit, `s1 <= SWI` and `s2 <= s1`. Only `s2` feeds the filter.
- **Counter:** one per bit, width `$clog2(STABLE_CYCLES+1)`.
  - If `s2 == sw_db`, the counter clears to 0.
  - If `s2 != sw_db` and the counter is below `STABLE_CYCLES-1`, the counter increments.
  - If `s2 != sw_db` and the counter equals `STABLE_CYCLES-1`, then `sw_db <= s2` and the counter clears.
- **Pulses:** `sw_rise`/`sw_fall` are registered. They are set on the same edge that updates `sw_db` (rise if the new value is 1, fall if 0) and cleared on the next edge.
- **Channels:** fully independent; no cross-bit interaction.
- **Glitches:** any return of `s2` to `sw_db` before acceptance clears the counter. A glitch shorter than `STABLE_CYCLES` samples produces no output change.
- **Asynchronous reset (`reset_n = 0`):** `s1`, `s2`, counters, `sw_db`, `sw_rise` and `sw_fall` all go to 0 immediately. This applies mid-count as well; the partial count is discarded.
- **After reset release:** a switch held at 1 is accepted as a normal rising transition, so `sw_rise` pulses once.
- **Counter overflow:** impossible by construction; the counter never exceeds `STABLE_CYCLES-1`.

## Timing
- A `SWI` change captured at edge E0 (into `s1`) reaches `s2` at E1.
- `sw_db` updates at E(1+`STABLE_CYCLES`). The default latency is 5 edges.
- `sw_rise`/`sw_fall` are high for exactly one cycle, aligned with the first cycle of the new `sw_db` value.
- Minimum spacing between accepted transitions on one bit is `STABLE_CYCLES` cycles.
- All outputs come directly from flops; there is no combinational path from `SWI` to any output.

## Configuration
- Macro `SW_DEBOUNCE_EDGE_EN`.
  - **Defined:** `sw_rise`/`sw_fall` behave as above.
  - **Undefined:** the edge-pulse flops are not built, and `sw_rise`/`sw_fall` are tied to 0. `sw_db` behaviour and latency are identical in both cases.

## Test plan
1. **Reset, then stable rise:** hold `reset_n = 0` with `SWI = 8'hFF`, then release.
   - Required: all outputs 0 during reset.
   - Required: `sw_db = 8'hFF` and `sw_rise = 8'hFF` for one cycle, 5 edges after release.
   - Required: `sw_rise = 0` on the following edge.
2. **Clean toggle (default parameters):** `SWI[1]` goes 0→1 at E0.
   - Required: `sw_db[1] = 1` and `sw_rise[1] = 1` at E5; `sw_rise[1] = 0` at E6.
   - Required: all other bits unchanged.
3. **Bounce rejection:** `SWI[0]` toggles 1,0,1,0 on consecutive cycles, then stays 1.
   - Required: no pulses during the toggling.
   - Required: exactly one `sw_rise[0]`, 5 edges after the last 0→1 toggle.
4. **Glitch of `STABLE_CYCLES-1` samples:** `SWI[3]` is high for 3 cycles, then low.
   - Required: `sw_db[3]` stays 0; no pulses.
5. **Reset mid-count:** `SWI[2]` rises at E0; assert `reset_n` between E2 and E3; release at E6 with `SWI[2]` still 1.
   - Required: counter restarts from 0.
   - Required: `sw_db[2] = 1` 5 edges after release, with one `sw_rise[2]`.
6. **Independence plus macro off:** `SWI = 8'h0F → 8'hF0`.
   - Required: `sw_db = 8'hF0` after 5 edges.
   - Required, with `SW_DEBOUNCE_EDGE_EN` defined: `sw_rise = 8'hF0` and `sw_fall = 8'h0F` in the same cycle.
   - Required, with the macro undefined: both pulse outputs stay 0.
